// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR sequencer defaults, state encoding and Q15 saturation limits.
package fir_pkg;
    localparam int NTAPS_D = 16;
    localparam int AW_D = 4;
    localparam int DW_D = 16;
    typedef enum logic [2:0] {CLEAR, IDLE, WRITE, FETCH, DRAIN, DONE} state_t;
    function automatic int acc_w(int aw, int dw);
        return 2 * dw + aw;
    endfunction
    function automatic longint sat_hi(int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction
    function automatic longint sat_lo(int dw);
        return -(longint'(1) << (dw - 1));
    endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with clear/enable and rounded, saturated output.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW = DW_D,
    parameter int AW = AW_D
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic        [DW-1:0] result
);
    localparam int ACCW = acc_w(AW, DW);
    localparam logic signed [ACCW-1:0] HI = ACCW'(sat_hi(DW));
    localparam logic signed [ACCW-1:0] LO = ACCW'(sat_lo(DW));
    localparam logic signed [ACCW-1:0] HALF = ACCW'(longint'(1) << (DW - 2));
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] ext, acc, acc_nxt, sum, rnd;
    always_comb begin
        prod = a * b;
        ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        acc_nxt = en ? acc + ext : acc;
        // result reflects the sum including this cycle's product
        sum = acc_nxt + HALF;
        rnd = sum >>> (DW - 1);
        result = rnd > HI ? HI[DW-1:0] : rnd < LO ? LO[DW-1:0] : rnd[DW-1:0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else acc <= clr ? '0 : acc_nxt;
    end
endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: per-sample FIR sequencing over external sample RAM and coefficient ROM.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_D,
    parameter int AW = AW_D,
    parameter int DW = DW_D
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_end,
    input  logic [DW-1:0] sample_in,
    input  logic          overrun_clr,
    output logic [AW-1:0] smp_addr,
    output logic          smp_we,
    output logic [DW-1:0] smp_wdata,
    input  logic [DW-1:0] smp_rdata,
    output logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_rdata,
    output logic [DW-1:0] sample_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
    state_t state, state_nxt;
    logic [AW-1:0] head, clr_cnt, k;
    logic [DW-1:0] smp_lat, result;
    logic vld;
    fir_mac #(.DW(DW), .AW(AW)) u_mac (
        .clk(clk),
        .reset_n(reset_n),
        .clr(state == WRITE),
        .en(vld),
        .a(smp_rdata),
        .b(coef_rdata),
        .result(result)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            head <= '0;
            clr_cnt <= '0;
            k <= '0;
            smp_lat <= '0;
            vld <= 1'b0;
            sample_out <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            clr_cnt <= clr_cnt + AW'(state == CLEAR);
            k <= state == FETCH ? k + AW'(1) : '0;
            smp_lat <= state == IDLE && sample_end ? sample_in : smp_lat;
            vld <= state == FETCH;
            // output registered at the end of DRAIN so it is valid during DONE alongside out_valid
            sample_out <= state == DRAIN ? result : sample_out;
            out_valid <= state == DRAIN;
            head <= head + AW'(state == DONE);
            overrun <= (sample_end && state != IDLE) || (overrun && !overrun_clr);
        end
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:   state_nxt = clr_cnt == LAST ? IDLE : CLEAR;
            IDLE:    state_nxt = sample_end ? WRITE : IDLE;
            WRITE:   state_nxt = FETCH;
            FETCH:   state_nxt = k == LAST ? DRAIN : FETCH;
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        busy = state != IDLE;
        smp_we = reset_n && (state == CLEAR || state == WRITE);
        smp_addr = state == CLEAR ? clr_cnt : state == FETCH ? head - k : head;
        smp_wdata = state == WRITE ? smp_lat : '0;
        coef_addr = state == FETCH ? k : '0;
    end
endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
Sequences the per-sample FIR computation: on each codec sample strobe it writes the new sample into a circular sample RAM, then walks all taps. Each tap is a paired read of sample RAM and coefficient ROM. The block accumulates the products and emits one rounded, saturated Q15 output per input sample. It sits between the codec sample strobes and the fir_filter memories, all in the main_clk domain. The RAM and ROM are external, each with a synchronous 1-cycle read.

Parameters:
NTAPS, 16, number of filter taps (power of 2, 2..256)
AW, 4, address width, log2(NTAPS)
DW, 16, sample/coefficient width, signed two's complement (Q15 coefficients)

Ports:
clk  in  1  main clock
reset_n  in  1  asynchronous, active-low reset
sample_end  in  1  one-cycle strobe: new input sample valid on sample_in (already synchronised to clk)
sample_in  in  DW  input sample
overrun_clr  in  1  clears sticky overrun flag
smp_addr  out  AW  sample RAM address
smp_we  out  1  sample RAM write enable
smp_wdata  out  DW  sample RAM write data
smp_rdata  in  DW  sample RAM read data, valid 1 cycle after address
coef_addr  out  AW  coefficient ROM address
coef_rdata  in  DW  coefficient read data, valid 1 cycle after address
sample_out  out  DW  filtered sample, held until next result
out_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high in every state except IDLE
overrun  out  1  sticky: a sample_end arrived while busy

Behaviour:
- Reset (async assert, sync release): state=CLEAR, head=0, clr_cnt=0, acc=0, sample_out=0, out_valid=0, overrun=0, smp_we=0, all addresses=0.
- CLEAR: one cycle per location, NTAPS cycles total. Drive smp_we=1, smp_wdata=0, smp_addr=clr_cnt, clr_cnt++. After address NTAPS-1, go to IDLE.
- IDLE: busy=0, smp_we=0. A sample_end here moves the block to WRITE and latches sample_in.
- WRITE (1 cycle): smp_addr=head, smp_we=1, smp_wdata=latched sample. Clear acc and set k=0.
- FETCH (NTAPS cycles, k=0..NTAPS-1): smp_addr=(head-k) mod NTAPS, coef_addr=k, smp_we=0. A valid flag delayed one cycle qualifies the accumulate.
- Accumulate: in the cycle after each FETCH address, acc <= acc + smp_rdata*coef_rdata. acc is signed, 2*DW+AW bits, and never overflows.
- DRAIN (1 cycle): accumulates the last product.
- DONE (1 cycle): sample_out <= sat_DW((acc + 2^(DW-2)) >>> (DW-1)), i.e. round half up, arithmetic shift.
  - Result above 2^(DW-1)-1 -> 0x7FFF; below -2^(DW-1) -> 0x8000.
  - out_valid=1 this cycle only.
  - head <= head+1 mod NTAPS, wrapping NTAPS-1 -> 0.
  - Next state is IDLE.
- Latency: sample_end sampled in cycle T; out_valid is high in cycle T+NTAPS+3. Minimum sample spacing is NTAPS+4 cycles.
- sample_end in any state other than IDLE (including CLEAR and DONE): the sample is dropped, overrun <= 1, and the sequence in progress is unaffected.
- overrun_clr clears overrun. If it coincides with a dropped sample_end, the set wins.
- Reset mid-operation: immediate return to reset values, a new CLEAR pass, and no out_valid for the interrupted sample.
- Write-then-read of the same address in consecutive cycles (WRITE then FETCH k=0) relies on RAM write-before-next-read. This is a requirement on the RAM.

Decomposition:
- Shared package/include fir_pkg: NTAPS/AW/DW defaults, accumulator width, state encoding (CLEAR, IDLE, WRITE, FETCH, DRAIN, DONE), Q15 saturation limits.
- One sub-module fir_mac: signed multiply, accumulate with clear and enable, round/saturate output function.
- fir_sequencer holds the FSM, pointers and flags.

Test Plan:
1. Reset release -> busy high exactly 16 cycles; smp_we=1 with wdata=0 at addresses 0..15 in order; then busy=0, out_valid never asserted.
2. coef[0]=0x7FFF, others 0; input 0x1234 -> sample_out=0x1234, out_valid pulse exactly 19 cycles after sample_end.
3. coef[3]=0x4000, others 0; inputs 1000,0,0,0 spaced 30 cycles -> outputs 0,0,0,500.
4. All coefs 0x7FFF; 16 inputs of 0x7FFF -> final output 0x7FFF. Repeat with inputs 0x8000 -> final output 0x8000 (both saturated).
5. Overrun: sample_end at T and T+5 -> exactly one out_valid, overrun=1 until overrun_clr; overrun_clr on the same cycle as a dropped sample_end -> overrun stays 1.
6. Wrap and reset: 20 impulse-response samples with head wrapping 15->0 match a reference model. Then assert reset_n low mid-FETCH -> outputs return to reset values, CLEAR re-runs, and no out_valid appears for the aborted sample.
